// File: rtl/decode_stage_pkg.sv
// Shared opcode/funct constants, ALU encoding and pipeline-register layouts
// for the instruction-decode stage.
package decode_stage_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_e;

    typedef struct packed {
        alu_op_e    alu_op;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic [4:0] dest;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        ctrl_t       ctrl;
    } idex_t;

    function automatic logic [31:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/decode_stage_register_file.sv
// Register file: two combinational read ports with write bypass, one write port.
// Latency: reads 0 cycles, writes visible to the array after the edge (bypass covers the same cycle).
// Backpressure: none; every write is accepted.
module register_file #(
    parameter int NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b
);

    logic [31:0] regs_q [NUM_REGS];
    logic [31:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (we && waddr != 5'd0) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Register 0 wins over the bypass so writes to $0 never leak out.
    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        if (raddr_a != 5'd0) begin
            rdata_a = (we && waddr == raddr_a) ? wdata : regs_q[raddr_a];
        end
        if (raddr_b != 5'd0) begin
            rdata_b = (we && waddr == raddr_b) ? wdata : regs_q[raddr_b];
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: IF/ID register, register read, control decode, j/beq resolution, ID/EX register.
// Latency: instruction in IF/ID one edge after fetch, ID/EX outputs valid after the following edge.
// Backpressure: stall holds fetch and IF/ID and injects an ID/EX bubble; jump flushes IF/ID.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int          NUM_REGS = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instruction_Code,
    input  logic [31:0] PC,
    output logic        stall,
    output logic        jump,
    output logic [31:0] extended,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_dest,
    input  logic        mem_reg_write,
    input  logic [4:0]  mem_dest,
    output logic [31:0] id_ex_rs_data,
    output logic [31:0] id_ex_rt_data,
    output logic [31:0] id_ex_imm,
    output logic [4:0]  id_ex_rs,
    output logic [4:0]  id_ex_rt,
    output logic [4:0]  id_ex_dest,
    output logic [2:0]  id_ex_alu_op,
    output logic        id_ex_alu_src,
    output logic        id_ex_mem_read,
    output logic        id_ex_mem_write,
    output logic        id_ex_reg_write,
    output logic        id_ex_mem_to_reg
);

    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    idex_t       idex_q, idex_d;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_data, rt_data, imm, pc4, branch_target;
    ctrl_t       ctrl;
    logic        is_j, is_beq, uses_rt, rtype_ok;
    logic        load_use, branch_dep;

    assign opcode = ifid_instr_q[31:26];
    assign rs     = ifid_instr_q[25:21];
    assign rt     = ifid_instr_q[20:16];
    assign rd     = ifid_instr_q[15:11];
    assign funct  = ifid_instr_q[5:0];
    assign imm    = sign_ext16(ifid_instr_q[15:0]);

    register_file #(
        .NUM_REGS (NUM_REGS)
    ) u_register_file (
        .clk     (clk),
        .rst_n   (reset),
        .we      (wb_we),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (rs),
        .raddr_b (rt),
        .rdata_a (rs_data),
        .rdata_b (rt_data)
    );

    always_comb begin
        ctrl     = '0;
        is_j     = 1'b0;
        is_beq   = 1'b0;
        uses_rt  = 1'b0;
        rtype_ok = 1'b1;
        unique case (opcode)
            OP_RTYPE: begin
                uses_rt = 1'b1;
                case (funct)
                    FN_ADD:  ctrl.alu_op = ALU_ADD;
                    FN_SUB:  ctrl.alu_op = ALU_SUB;
                    FN_AND:  ctrl.alu_op = ALU_AND;
                    FN_OR:   ctrl.alu_op = ALU_OR;
                    FN_SLT:  ctrl.alu_op = ALU_SLT;
                    default: rtype_ok    = 1'b0;
                endcase
                if (rtype_ok) begin
                    ctrl.reg_write = 1'b1;
                    ctrl.dest      = rd;
                end else begin
                    ctrl = '0;
                end
            end
            OP_ADDI: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.dest      = rt;
            end
            OP_LW: begin
                ctrl.alu_src    = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.dest       = rt;
            end
            OP_SW: begin
                uses_rt        = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            OP_BEQ: begin
                uses_rt = 1'b1;
                is_beq  = 1'b1;
            end
            OP_J:    is_j = 1'b1;
            default: ctrl = '0;
        endcase
    end

    // beq compares in decode, so it must wait for any in-flight producer of its operands.
    always_comb begin
        load_use   = ex_mem_read && ex_dest != 5'd0 &&
                     (ex_dest == rs || (uses_rt && ex_dest == rt));
        branch_dep = is_beq &&
                     ((ex_reg_write && ex_dest != 5'd0 && (ex_dest == rs || ex_dest == rt)) ||
                      (mem_reg_write && mem_dest != 5'd0 && (mem_dest == rs || mem_dest == rt)));
        stall      = load_use || branch_dep;

        pc4           = ifid_pc_q + 32'd4;
        branch_target = pc4 + (imm << 2);
        jump          = !stall && (is_j || (is_beq && rs_data == rt_data));
        extended      = is_j ? {pc4[31:28], ifid_instr_q[25:0], 2'b00} : branch_target;
    end

    always_comb begin
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        if (!stall) begin
            ifid_instr_d = jump ? NOP_INSTR : Instruction_Code;
            ifid_pc_d    = PC;
        end

        idex_d = '0;
        if (!stall && !jump) begin
            idex_d.rs_data = rs_data;
            idex_d.rt_data = rt_data;
            idex_d.imm     = imm;
            idex_d.rs      = rs;
            idex_d.rt      = rt;
            idex_d.ctrl    = ctrl;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= RESET_PC;
            idex_q       <= '0;
        end else begin
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            idex_q       <= idex_d;
        end
    end

    assign id_ex_rs_data    = idex_q.rs_data;
    assign id_ex_rt_data    = idex_q.rt_data;
    assign id_ex_imm        = idex_q.imm;
    assign id_ex_rs         = idex_q.rs;
    assign id_ex_rt         = idex_q.rt;
    assign id_ex_dest       = idex_q.ctrl.dest;
    assign id_ex_alu_op     = idex_q.ctrl.alu_op;
    assign id_ex_alu_src    = idex_q.ctrl.alu_src;
    assign id_ex_mem_read   = idex_q.ctrl.mem_read;
    assign id_ex_mem_write  = idex_q.ctrl.mem_write;
    assign id_ex_reg_write  = idex_q.ctrl.reg_write;
    assign id_ex_mem_to_reg = idex_q.ctrl.mem_to_reg;

endmodule
